// File: rtl/apb_uart_csr_if.sv
// APB3/APB4 bus bundle between the fabric (master) and the UART CSR block (slave).
interface apb_uart_csr_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_uart_csr.sv
// APB register block for the UART: DATA/BAUD/CTRL/IER/ISR/STATUS with wait states and slave errors.
// Define UART_CSR_PROT_EN to reject unprivileged writes (pprot[0]=0) to BAUD, CTRL and IER.
module apb_uart_csr #(
    parameter int DATA_W      = 8,
    parameter int BAUD_W      = 16,
    parameter int BAUD_RST    = 977,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_uart_csr_if.slave     apb,
    input  logic              tx_full,
    input  logic              tx_empty,
    input  logic              rx_empty,
    input  logic              rx_full,
    input  logic [DATA_W-1:0] rx_data,
    output logic              tx_push,
    output logic [DATA_W-1:0] tx_data,
    output logic              rx_pop,
    output logic [BAUD_W-1:0] baud_val,
    output logic              ip_en,
    output logic              parity_en,
    output logic              parity_type,
    output logic [1:0]        tx_thr_val,
    output logic [1:0]        rx_thr_val,
    input  logic              ev_tx_thr,
    input  logic              ev_rx_thr,
    input  logic              ev_rx_ov,
    input  logic              ev_rx_pe,
    input  logic              ev_rx_fre,
    output logic              irq
);
    localparam logic [1:0]  WS     = 2'(WAIT_STATES);
    localparam logic [31:0] A_DATA = 32'h00;
    localparam logic [31:0] A_BAUD = 32'h04;
    localparam logic [31:0] A_CTRL = 32'h08;
    localparam logic [31:0] A_IER  = 32'h0C;
    localparam logic [31:0] A_ISR  = 32'h10;
    localparam logic [31:0] A_STAT = 32'h14;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state;
    logic [1:0]  wcnt;
    logic [7:0]  ctrl_q;
    logic [4:0]  ier_q;
    logic [4:0]  isr_q;
    logic [4:0]  ev;
    logic [4:0]  ev_q;
    logic [4:0]  isr_clr;
    logic [31:0] rd_mux;
    logic        done;
    logic        sel_data, sel_baud, sel_ctrl, sel_ier, sel_isr, sel_stat;
    logic        addr_bad, prot_bad, err;
    logic        wr_ok, rd_ok;
    logic        unused_bits;

    assign ev = {ev_rx_fre, ev_rx_pe, ev_rx_ov, ev_rx_thr, ev_tx_thr};

    assign sel_data = apb.paddr == A_DATA;
    assign sel_baud = apb.paddr == A_BAUD;
    assign sel_ctrl = apb.paddr == A_CTRL;
    assign sel_ier  = apb.paddr == A_IER;
    assign sel_isr  = apb.paddr == A_ISR;
    assign sel_stat = apb.paddr == A_STAT;
    assign addr_bad = (apb.paddr[1:0] != 2'b00) || (apb.paddr > A_STAT);

`ifdef UART_CSR_PROT_EN
    assign prot_bad = apb.pwrite & (sel_baud | sel_ctrl | sel_ier) & ~apb.pprot[0];
`else
    assign prot_bad = 1'b0;
`endif

    // Only bits that some register consumes are decoded; the rest is intentionally ignored.
    assign unused_bits = ^{apb.pprot, apb.pwdata, apb.pstrb[3:2]};

    assign err = addr_bad
               | (apb.pwrite & (sel_stat | ~apb.pstrb[0] | (sel_data & tx_full)
                                | (sel_baud & ~apb.pstrb[1]) | prot_bad))
               | (~apb.pwrite & sel_data & rx_empty);

    // Completion is the last ACCESS cycle with the master still holding the transfer.
    assign done  = (state == ACCESS) && apb.psel && apb.penable && (wcnt == WS);
    assign wr_ok = done & apb.pwrite & ~err;
    assign rd_ok = done & ~apb.pwrite & ~err;

    always_comb begin
        rd_mux = '0;
        if (sel_data)      rd_mux = 32'(rx_data);
        else if (sel_baud) rd_mux = 32'(baud_val);
        else if (sel_ctrl) rd_mux = 32'(ctrl_q);
        else if (sel_ier)  rd_mux = 32'(ier_q);
        else if (sel_isr)  rd_mux = 32'(isr_q);
        else if (sel_stat) rd_mux = {28'h0, rx_full, rx_empty, tx_full, tx_empty};
    end

    assign apb.pready  = done;
    assign apb.pslverr = done & err;
    assign apb.prdata  = rd_ok ? rd_mux : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                IDLE: if (apb.psel && !apb.penable) state <= SETUP;
                SETUP: begin
                    if (!apb.psel) begin
                        state <= IDLE;
                    end else if (apb.penable) begin
                        state <= ACCESS;
                        wcnt  <= '0;
                    end
                end
                ACCESS: begin
                    // Losing psel/penable aborts; completion also returns to IDLE, which picks up
                    // a back-to-back SETUP on the following cycle without losing alignment.
                    if (!(apb.psel && apb.penable) || wcnt == WS) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_push  <= 1'b0;
            rx_pop   <= 1'b0;
            tx_data  <= '0;
            baud_val <= BAUD_W'(BAUD_RST);
            ctrl_q   <= '0;
            ier_q    <= '0;
        end else begin
            tx_push <= wr_ok & sel_data;
            rx_pop  <= rd_ok & sel_data;
            if (wr_ok & sel_data) tx_data  <= apb.pwdata[DATA_W-1:0];
            if (wr_ok & sel_baud) baud_val <= apb.pwdata[BAUD_W-1:0];
            if (wr_ok & sel_ctrl) ctrl_q   <= apb.pwdata[7:0] & 8'hF7;
            if (wr_ok & sel_ier)  ier_q    <= apb.pwdata[4:0];
        end
    end

    assign ip_en       = ctrl_q[0];
    assign parity_en   = ctrl_q[1];
    assign parity_type = ctrl_q[2];
    assign tx_thr_val  = ctrl_q[5:4];
    assign rx_thr_val  = ctrl_q[7:6];

    assign isr_clr = (wr_ok & sel_isr) ? apb.pwdata[4:0] : 5'h0;

    // A fresh edge in the same cycle as a W1C wins, so no event is ever lost.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ev_q  <= '0;
            isr_q <= '0;
            irq   <= 1'b0;
        end else begin
            ev_q  <= ev;
            isr_q <= (isr_q & ~isr_clr) | (ev & ~ev_q);
            irq   <= |(isr_q & ier_q);
        end
    end
endmodule

// File: tb/tb_apb_uart_csr.sv
// Self-checking bench for apb_uart_csr: directed scenarios plus randomized traffic against a register model.
module tb_apb_uart_csr;
    localparam int WS = 2;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    apb_uart_csr_if bus();

    logic        tx_full = 1'b0, tx_empty = 1'b1, rx_empty = 1'b1, rx_full = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        tx_push, rx_pop, irq;
    logic [7:0]  tx_data;
    logic [15:0] baud_val;
    logic        ip_en, parity_en, parity_type;
    logic [1:0]  tx_thr_val, rx_thr_val;
    logic [4:0]  ev = 5'h0;

    apb_uart_csr #(.DATA_W(8), .BAUD_W(16), .BAUD_RST(977), .WAIT_STATES(WS)) dut (
        .pclk(pclk), .presetn(presetn), .apb(bus),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_empty(rx_empty), .rx_full(rx_full),
        .rx_data(rx_data), .tx_push(tx_push), .tx_data(tx_data), .rx_pop(rx_pop),
        .baud_val(baud_val), .ip_en(ip_en), .parity_en(parity_en), .parity_type(parity_type),
        .tx_thr_val(tx_thr_val), .rx_thr_val(rx_thr_val),
        .ev_tx_thr(ev[0]), .ev_rx_thr(ev[1]), .ev_rx_ov(ev[2]), .ev_rx_pe(ev[3]), .ev_rx_fre(ev[4]),
        .irq(irq)
    );

    int checks = 0, errors = 0;
    int push_cnt = 0, pop_cnt = 0;
    bit b2b_pending = 0;
    logic [2:0] cur_prot = 3'b001;

    // register model
    logic [15:0] m_baud;
    logic [7:0]  m_ctrl, m_txd;
    logic [4:0]  m_ier, m_isr;
    int          exp_push, exp_pop;

    always @(posedge pclk) begin
        if (tx_push === 1'b1) push_cnt++;
        if (rx_pop === 1'b1) pop_cnt++;
    end

    function automatic void model_reset();
        m_baud = 16'd977; m_ctrl = 8'h0; m_txd = 8'h0; m_ier = 5'h0; m_isr = 5'h0;
        exp_push = push_cnt; exp_pop = pop_cnt;
    endfunction

    function automatic void model_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s, output bit e, output logic [31:0] r);
        e = 0; r = 32'h0;
        if (a[1:0] != 2'b00 || a > 32'h14) e = 1;
        else if (w) begin
            if (a == 32'h14 || !s[0]) e = 1;
            else if (a == 32'h0 && tx_full) e = 1;
            else if (a == 32'h4 && !s[1]) e = 1;
`ifdef UART_CSR_PROT_EN
            else if ((a == 32'h4 || a == 32'h8 || a == 32'hC) && !cur_prot[0]) e = 1;
`endif
        end else if (a == 32'h0 && rx_empty) e = 1;
        if (!e) begin
            if (w) begin
                case (a)
                    32'h0:  begin exp_push++; m_txd = d[7:0]; end
                    32'h4:  m_baud = d[15:0];
                    32'h8:  m_ctrl = d[7:0] & 8'hF7;
                    32'hC:  m_ier = d[4:0];
                    32'h10: m_isr = m_isr & ~d[4:0];
                    default: ;
                endcase
            end else begin
                case (a)
                    32'h0:  begin r = {24'h0, rx_data}; exp_pop++; end
                    32'h4:  r = {16'h0, m_baud};
                    32'h8:  r = {24'h0, m_ctrl};
                    32'hC:  r = {27'h0, m_ier};
                    32'h10: r = {27'h0, m_isr};
                    default: r = {28'h0, rx_full, rx_empty, tx_full, tx_empty};
                endcase
            end
        end
    endfunction

    // One APB transfer; lat counts cycles from SETUP to the cycle pready is seen.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, input logic [4:0] pulse, input bit hold,
                        output logic [31:0] rd, output bit er, output int lat);
        bit got = 0;
        if (!b2b_pending) begin @(posedge pclk); #1; end
        bus.psel = 1; bus.penable = 0; bus.pwrite = w; bus.paddr = a;
        bus.pwdata = d; bus.pstrb = s; bus.pprot = p;
        lat = 0; rd = 32'h0; er = 0;
        @(negedge pclk);
        @(posedge pclk); #1 bus.penable = 1;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge pclk);
            lat++;
            if (bus.pready === 1'b1) begin
                got = 1; rd = bus.prdata; er = bus.pslverr;
                ev = ev | pulse;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL xfer_timeout addr=%h no pready within 12 cycles", a);
        end
        @(posedge pclk); #1;
        ev = ev & ~pulse;
        b2b_pending = hold;
        if (!hold) begin bus.psel = 0; bus.penable = 0; end
    endtask

    task automatic settle();
        @(posedge pclk); @(negedge pclk);
    endtask

    task automatic test_reset();
        logic [31:0] rd; bit er; int lat;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0;
        bus.pwdata = 0; bus.pstrb = 0; bus.pprot = 0;
        presetn = 0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        checks++; if (baud_val !== 16'd977) begin errors++; $display("FAIL reset_baud got=%0d exp=977", baud_val); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if ({tx_push, rx_pop, bus.pready, bus.pslverr} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {tx_push, rx_pop, bus.pready, bus.pslverr}); end
        checks++; if ({rx_thr_val, tx_thr_val, parity_type, parity_en, ip_en, tx_data} !== 15'h0) begin
            errors++; $display("FAIL reset_ctrl got=%h exp=0", {rx_thr_val, tx_thr_val, parity_type, parity_en, ip_en, tx_data}); end
        presetn = 1;
        model_reset();
        xfer(0, 32'h4, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'h3D1 || er !== 1'b0) begin errors++; $display("FAIL reset_read_baud got=%h err=%b exp=3d1 err=0", rd, er); end
        checks++; if (lat != 2 + WS) begin errors++; $display("FAIL read_latency got=%0d exp=%0d", lat, 2 + WS); end
    endtask

    task automatic test_tx_push();
        logic [31:0] rd; bit er; int lat;
        tx_full = 0;
        xfer(1, 32'h0, 32'h5A, 4'hF, 3'b001, 5'h0, 0, rd, er, lat);
        checks++; if (lat != 2 + WS || er !== 1'b0) begin errors++; $display("FAIL tx_write_lat got=%0d err=%b exp=%0d err=0", lat, er, 2 + WS); end
        checks++; if (tx_push !== 1'b1 || tx_data !== 8'h5A) begin errors++; $display("FAIL tx_push_pulse got=%b/%h exp=1/5a", tx_push, tx_data); end
        @(posedge pclk); #1;
        checks++; if (tx_push !== 1'b0) begin errors++; $display("FAIL tx_push_width got=%b exp=0", tx_push); end
        exp_push++; m_txd = 8'h5A;
    endtask

    task automatic test_rx();
        logic [31:0] rd; bit er; int lat; int pc;
        pc = pop_cnt;
        rx_empty = 1;
        xfer(0, 32'h0, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        settle();
        checks++; if (er !== 1'b1 || pop_cnt != pc) begin errors++; $display("FAIL rx_empty_read err=%b pops=%0d exp err=1 pops=%0d", er, pop_cnt, pc); end
        rx_empty = 0; rx_data = 8'h33;
        @(posedge pclk); #1;
        xfer(0, 32'h0, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'h33 || er !== 1'b0) begin errors++; $display("FAIL rx_read got=%h err=%b exp=33 err=0", rd, er); end
        checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop_pulse got=%b exp=1", rx_pop); end
        settle();
        checks++; if (rx_pop !== 1'b0 || pop_cnt != pc + 1) begin errors++; $display("FAIL rx_pop_once got=%b pops=%0d exp 0/%0d", rx_pop, pop_cnt, pc + 1); end
        exp_pop = pop_cnt;
        rx_empty = 1;
    endtask

    task automatic test_irq();
        logic [31:0] rd; bit er; int lat;
        xfer(1, 32'hC, 32'h4, 4'hF, 3'b001, 5'h0, 0, rd, er, lat);
        @(negedge pclk) ev = 5'b00100;
        @(negedge pclk) ev = 5'b00000;
        xfer(0, 32'h10, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        settle();
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL isr_set got=%h exp=4", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
        xfer(1, 32'h10, 32'h4, 4'hF, 3'b001, 5'h0, 0, rd, er, lat);
        settle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
        xfer(1, 32'h10, 32'h4, 4'hF, 3'b001, 5'b00100, 0, rd, er, lat);
        xfer(0, 32'h10, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        settle();
        checks++; if (rd !== 32'h4 || irq !== 1'b1) begin errors++; $display("FAIL set_beats_clear isr=%h irq=%b exp=4/1", rd, irq); end
        xfer(1, 32'h10, 32'h1F, 4'hF, 3'b001, 5'h0, 0, rd, er, lat);
        xfer(1, 32'hC, 32'h0, 4'hF, 3'b001, 5'h0, 0, rd, er, lat);
    endtask

    task automatic test_errors();
        logic [31:0] rd; bit er; int lat; int pc;
        logic [31:0] a [7];
        logic [3:0]  s [7];
        a = '{32'h06, 32'h18, 32'h14, 32'h04, 32'h08, 32'h00, 32'h100};
        s = '{4'hF, 4'hF, 4'hF, 4'h1, 4'hE, 4'hF, 4'hF};
        pc = push_cnt;
        tx_full = 1;
        for (int i = 0; i < 7; i++) begin
            xfer(1, a[i], 32'hFFFF_FFFF, s[i], 3'b001, 5'h0, 0, rd, er, lat);
            checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_write[%0d] addr=%h got=%b exp=1", i, a[i], er); end
        end
        xfer(0, 32'h1C, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_read_oor got=%b exp=1", er); end
        tx_full = 0;
        settle();
        checks++; if (baud_val !== 16'd977 || {rx_thr_val, tx_thr_val, parity_type, parity_en, ip_en} !== 7'h0 || push_cnt != pc || irq !== 1'b0) begin
            errors++; $display("FAIL err_no_effect baud=%0d ctrl=%h pushes=%0d irq=%b exp 977/0/%0d/0", baud_val,
                                {rx_thr_val, tx_thr_val, parity_type, parity_en, ip_en}, push_cnt, pc, irq); end
    endtask

    task automatic test_prot();
        logic [31:0] rd; bit er; int lat;
`ifdef UART_CSR_PROT_EN
        xfer(1, 32'h8, 32'h7, 4'hF, 3'b000, 5'h0, 0, rd, er, lat);
        settle();
        checks++; if (er !== 1'b1 || {parity_type, parity_en, ip_en} !== 3'b000) begin
            errors++; $display("FAIL prot_reject err=%b ctrl=%b exp 1/000", er, {parity_type, parity_en, ip_en}); end
`endif
        xfer(1, 32'h8, 32'h7, 4'hF, 3'b001, 5'h0, 0, rd, er, lat);
        settle();
        checks++; if (er !== 1'b0 || {parity_type, parity_en, ip_en} !== 3'b111) begin
            errors++; $display("FAIL prot_accept err=%b ctrl=%b exp 0/111", er, {parity_type, parity_en, ip_en}); end
        xfer(0, 32'h8, 0, 4'h0, 3'b000, 5'h0, 0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h7) begin errors++; $display("FAIL prot_read got=%h err=%b exp 7/0", rd, er); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; bit er; int lat; int pc; bit saw;
        pc = push_cnt; saw = 0;
        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 0; bus.pwdata = 32'h77; bus.pstrb = 4'hF;
        @(negedge pclk) saw |= bus.pready;
        @(posedge pclk); #1 bus.penable = 1;
        @(negedge pclk) saw |= bus.pready;
        @(posedge pclk); #1 bus.psel = 0; bus.penable = 0;
        repeat (4) @(negedge pclk) saw |= bus.pready;
        checks++; if (saw !== 1'b0 || push_cnt != pc || tx_data !== 8'h5A) begin
            errors++; $display("FAIL abort pready_seen=%b pushes=%0d tx_data=%h exp 0/%0d/5a", saw, push_cnt, pc, tx_data); end
        xfer(0, 32'h4, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'h3D1 || lat != 2 + WS) begin errors++; $display("FAIL after_abort got=%h lat=%0d exp 3d1/%0d", rd, lat, 2 + WS); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; bit er; int lat;
        xfer(1, 32'h4, 32'h1234, 4'hF, 3'b001, 5'h0, 1, rd, er, lat);
        xfer(1, 32'h8, 32'hFF, 4'hF, 3'b001, 5'h0, 1, rd, er, lat);
        checks++; if (er !== 1'b0 || lat != 2 + WS) begin errors++; $display("FAIL b2b_write lat=%0d err=%b exp %0d/0", lat, er, 2 + WS); end
        xfer(0, 32'h4, 0, 4'h0, 3'b001, 5'h0, 1, rd, er, lat);
        checks++; if (rd !== 32'h1234 || lat != 2 + WS) begin errors++; $display("FAIL b2b_read_baud got=%h lat=%0d exp 1234/%0d", rd, lat, 2 + WS); end
        xfer(0, 32'h8, 0, 4'h0, 3'b001, 5'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'hF7 || lat != 2 + WS) begin errors++; $display("FAIL b2b_read_ctrl got=%h lat=%0d exp f7/%0d", rd, lat, 2 + WS); end
        checks++; if ({rx_thr_val, tx_thr_val, parity_type, parity_en, ip_en} !== 7'h7F || baud_val !== 16'h1234) begin
            errors++; $display("FAIL b2b_outputs ctrl=%h baud=%h exp 7f/1234", {rx_thr_val, tx_thr_val, parity_type, parity_en, ip_en}, baud_val); end
    endtask

    task automatic test_reset_mid();
        int pc;
        pc = push_cnt;
        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 0; bus.pwdata = 32'h11; bus.pstrb = 4'hF;
        @(posedge pclk); #1 bus.penable = 1;
        @(posedge pclk);
        @(posedge pclk); #1 presetn = 0;
        @(posedge pclk); #1 bus.psel = 0; bus.penable = 0;
        @(negedge pclk) presetn = 1;
        settle();
        checks++; if (push_cnt != pc || tx_data !== 8'h00 || baud_val !== 16'd977) begin
            errors++; $display("FAIL reset_mid pushes=%0d tx_data=%h baud=%0d exp %0d/00/977", push_cnt, tx_data, baud_val, pc); end
        model_reset();
    endtask

    task automatic test_random();
        logic [31:0] rd, r_exp, a, d; bit er, e_exp, w; int lat; logic [3:0] s; logic [4:0] nev;
        for (int n = 0; n < 80; n++) begin
            nev = 5'($urandom);
            @(negedge pclk);
            m_isr = m_isr | (nev & ~ev);
            ev = nev;
            tx_full = 1'($urandom); tx_empty = 1'($urandom);
            rx_empty = 1'($urandom); rx_full = 1'($urandom);
            rx_data = 8'($urandom);
            case ($urandom_range(0, 11))
                0: a = 32'h00;  1: a = 32'h04;  2: a = 32'h08;  3: a = 32'h0C;
                4: a = 32'h10;  5: a = 32'h14;  6: a = 32'h18;  7: a = 32'h1C;
                8: a = 32'h06;  9: a = 32'h02; 10: a = 32'h11; default: a = 32'h100;
            endcase
            w = 1'($urandom);
            d = $urandom;
            s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            cur_prot = 3'($urandom);
            model_xfer(w, a, d, s, e_exp, r_exp);
            xfer(w, a, d, s, cur_prot, 5'h0, 0, rd, er, lat);
            settle();
            checks++; if (er !== e_exp || lat != 2 + WS) begin
                errors++; $display("FAIL rnd_err[%0d] w=%b a=%h s=%h got=%b lat=%0d exp=%b", n, w, a, s, er, lat, e_exp); end
            if (!w && !e_exp) begin
                checks++; if (rd !== r_exp) begin errors++; $display("FAIL rnd_rdata[%0d] a=%h got=%h exp=%h", n, a, rd, r_exp); end
            end
            checks++; if (baud_val !== m_baud || {rx_thr_val, tx_thr_val, 1'b0, parity_type, parity_en, ip_en} !== m_ctrl) begin
                errors++; $display("FAIL rnd_regs[%0d] baud=%h ctrl=%h exp %h/%h", n, baud_val,
                                    {rx_thr_val, tx_thr_val, 1'b0, parity_type, parity_en, ip_en}, m_baud, m_ctrl); end
            checks++; if (tx_data !== m_txd || push_cnt != exp_push || pop_cnt != exp_pop) begin
                errors++; $display("FAIL rnd_fifo[%0d] tx_data=%h pushes=%0d pops=%0d exp %h/%0d/%0d", n, tx_data,
                                    push_cnt, pop_cnt, m_txd, exp_push, exp_pop); end
            checks++; if (irq !== |(m_isr & m_ier)) begin errors++; $display("FAIL rnd_irq[%0d] got=%b exp=%b", n, irq, |(m_isr & m_ier)); end
        end
    endtask

    initial begin
        test_reset();
        test_tx_push();
        test_rx();
        test_irq();
        test_errors();
        test_prot();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
